scpu_prog_loader: RTL and testbench

Program loader and run sequencer for the SCPU pipeline. It accepts a program as a byte stream and writes the assembled 16-bit instructions into the instruction memory write port. It then sequences `ins_index` through the loaded program and returns each `res` value tagged with its instruction index. It is the write/drive end of the instruction-memory path that the CPU only reads.

---
 rtl/scpu_prog_loader.sv | 198 +++++++++++++++++++
 tb/tb_scpu_prog_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scpu_prog_loader.sv
// scpu_prog_loader: accepts a program as a byte stream (length header, then
// hi/lo instruction bytes), writes it into instruction memory, then sequences
// ins_index through the program and returns each CPU result tagged with its index.
// Optional trailing XOR checksum byte: define SCPU_LOADER_CKSUM_EN.
module scpu_prog_loader #(
   parameter int unsigned PIPE_LAT = 4,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [15:0]       im_wdata,
   output logic [ADDR_W-1:0] ins_index,
   input  logic [7:0]        cpu_res,
   output logic              out_valid,
   output logic [7:0]        out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Drain counter must reach PIPE_LAT
   localparam int unsigned DrainW = $clog2(PIPE_LAT + 2);

   typedef enum logic [2:0] {
      StIdle, StLoadHi, StLoadLo, StCksum, StRun, StDrain, StFin
   } state_e;

   state_e            state_q, state_d;
   logic              accept, start_run;
   logic              in_ready_q;
   logic [ADDR_W-1:0] len_q, cnt_q, pc_q;
   logic [ADDR_W-1:0] cnt_inc, last_pc;
   logic [7:0]        hi_q;
   logic [DrainW-1:0] drain_q;
   logic              im_we_q;
   logic [ADDR_W-1:0] im_addr_q;
   logic [15:0]       im_wdata_q;
   logic [PIPE_LAT-1:0] tag_v_q;
   logic [ADDR_W-1:0] tag_idx_q [PIPE_LAT];
   logic              out_valid_q;
   logic [7:0]        out_data_q;
   logic [ADDR_W-1:0] out_idx_q;

   assign accept    = in_valid && in_ready_q;
   assign cnt_inc   = cnt_q + 1'b1;
   assign last_pc   = len_q - 1'b1;
   assign start_run = (state_d == StRun) && (state_q != StRun);

   assign in_ready  = in_ready_q;
   assign im_we     = im_we_q;
   assign im_addr   = im_addr_q;
   assign im_wdata  = im_wdata_q;
   assign ins_index = pc_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;

`ifdef SCPU_LOADER_CKSUM_EN
   logic [7:0] csum_q;
   logic       err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Next-state decode and state-derived status outputs
   always_comb begin
      state_d = state_q;
      busy    = (state_q != StIdle);
      done    = (state_q == StFin);
      case (state_q)
         StIdle:   if (accept && (in_data != 8'h00)) state_d = StLoadHi;
         StLoadHi: if (accept) state_d = StLoadLo;
         StLoadLo: begin
            if (accept) begin
               if (cnt_inc == len_q) begin
`ifdef SCPU_LOADER_CKSUM_EN
                  state_d = StCksum;
`else
                  state_d = StRun;
`endif
               end else begin
                  state_d = StLoadHi;
               end
            end
         end
`ifdef SCPU_LOADER_CKSUM_EN
         StCksum:  if (accept) state_d = (in_data == csum_q) ? StRun : StFin;
`else
         StCksum:  state_d = StIdle;
`endif
         StRun:    if (pc_q == last_pc) state_d = StDrain;
         StDrain:  if (drain_q == DrainW'(PIPE_LAT)) state_d = StFin;
         StFin:    state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Byte capture, instruction-memory write port and pc sequencing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready_q <= 1'b0;
         len_q      <= '0;
         cnt_q      <= '0;
         pc_q       <= '0;
         hi_q       <= '0;
         drain_q    <= '0;
         im_we_q    <= 1'b0;
         im_addr_q  <= '0;
         im_wdata_q <= '0;
      end else begin
         im_we_q    <= 1'b0;
         in_ready_q <= state_d inside {StIdle, StLoadHi, StLoadLo, StCksum};
         case (state_q)
            StIdle: begin
               if (accept && (in_data != 8'h00)) begin
                  len_q <= ADDR_W'(in_data);
                  cnt_q <= '0;
               end
            end
            StLoadHi: if (accept) hi_q <= in_data;
            StLoadLo: begin
               if (accept) begin
                  im_we_q    <= 1'b1;
                  im_addr_q  <= cnt_q;
                  im_wdata_q <= {hi_q, in_data};
                  cnt_q      <= cnt_inc;
               end
            end
            StRun: begin
               drain_q <= '0;
               if (pc_q != last_pc) pc_q <= pc_q + 1'b1;
            end
            StDrain:  drain_q <= drain_q + 1'b1;
            default:  ;
         endcase
         if (start_run) pc_q <= '0;
      end
   end

   // Result tags track each presented index through the CPU pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_v_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         for (int i = 0; i < PIPE_LAT; i++) tag_idx_q[i] <= '0;
      end else begin
         tag_v_q[0]   <= (state_q == StRun);
         tag_idx_q[0] <= pc_q;
         for (int i = 1; i < PIPE_LAT; i++) begin
            tag_v_q[i]   <= tag_v_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
         out_valid_q <= tag_v_q[PIPE_LAT-1];
         if (tag_v_q[PIPE_LAT-1]) begin
            out_data_q <= cpu_res;
            out_idx_q  <= tag_idx_q[PIPE_LAT-1];
         end
      end
   end

`ifdef SCPU_LOADER_CKSUM_EN
   // Running XOR of instruction bytes; err is sticky until the next header
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csum_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         case (state_q)
            StIdle: begin
               if (in_data != 8'h00) begin
                  csum_q <= '0;
                  err_q  <= 1'b0;
               end
            end
            StLoadHi, StLoadLo: csum_q <= csum_q ^ in_data;
            StCksum:  if (in_data != csum_q) err_q <= 1'b1;
            default:  ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_scpu_prog_loader.sv
// Directed self-checking bench for scpu_prog_loader with a PIPE_LAT-stage CPU model.
module tb_scpu_prog_loader;

   localparam int PL = 4;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready;
   logic [7:0]  in_data;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [15:0] im_wdata;
   logic [7:0]  ins_index, cpu_res;
   logic        out_valid;
   logic [7:0]  out_data, out_idx;
   logic        busy, done, err;

   int cmp = 0;
   int mism = 0;
   int cyc = 0;
   int last_acc = 0;

   logic [7:0]  we_addr [$];
   logic [15:0] we_data [$];
   int          we_cyc  [$];
   logic [7:0]  ov_idx  [$];
   logic [7:0]  ov_data [$];
   int          ov_cyc  [$];
   int          done_cyc[$];
   logic [7:0]  idx_at  [int];
   logic        rdy_at  [int];
   logic [15:0] prog_w  [256];
   logic [7:0]  d1, d2, d3, d4;

   scpu_prog_loader #(.PIPE_LAT(PL), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .ins_index(ins_index),
      .cpu_res(cpu_res), .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // CPU model: res = ins_index + 0x10, PL edges later
   always @(posedge clk) begin
      d1 <= ins_index + 8'h10;
      d2 <= d1;
      d3 <= d2;
      d4 <= d3;
   end
   assign cpu_res = d4;

   // Event monitor, sampled mid-cycle
   always @(negedge clk) begin
      idx_at[cyc] = ins_index;
      rdy_at[cyc] = in_ready;
      if (im_we === 1'b1) begin
         we_addr.push_back(im_addr); we_data.push_back(im_wdata); we_cyc.push_back(cyc);
      end
      if (out_valid === 1'b1) begin
         ov_idx.push_back(out_idx); ov_data.push_back(out_data); ov_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
   end

   task automatic clear_mon();
      we_addr.delete(); we_data.delete(); we_cyc.delete();
      ov_idx.delete(); ov_data.delete(); ov_cyc.delete(); done_cyc.delete();
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted
   task automatic send_byte(input logic [7:0] b);
      int t;
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         cmp++; mism++;
         $display("FAIL send_timeout byte=%h got=in_ready low exp=in_ready high", b);
      end
      @(negedge clk);
      last_acc = cyc;
   endtask

   task automatic gap(input int n);
      if (n > 0) begin
         in_valid = 1'b0;
         repeat (n) @(negedge clk);
      end
   endtask

   task automatic send_prog(input int n, input int g);
      logic [7:0] x;
      x = 8'h00;
      send_byte(8'(n)); gap(g);
      for (int i = 0; i < n; i++) begin
         send_byte(prog_w[i][15:8]); gap(g);
         send_byte(prog_w[i][7:0]);  gap(g);
         x = x ^ prog_w[i][15:8] ^ prog_w[i][7:0];
      end
`ifdef SCPU_LOADER_CKSUM_EN
      send_byte(x);
`endif
      in_valid = 1'b0;
   endtask

   // Returns at the negedge of the cycle after done
   task automatic wait_done(input int budget, input string name);
      int t;
      t = 0;
      while (done !== 1'b1 && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (t >= budget) begin
         cmp++; mism++;
         $display("FAIL %s_done_timeout got=no done exp=done pulse", name);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(negedge clk);
      cmp++; if (in_ready !== 1'b0) begin mism++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      cmp++; if (im_we !== 1'b0) begin mism++; $display("FAIL rst_im_we got=%b exp=0", im_we); end
      cmp++; if (im_addr !== 8'h00) begin mism++; $display("FAIL rst_im_addr got=%h exp=00", im_addr); end
      cmp++; if (im_wdata !== 16'h0) begin mism++; $display("FAIL rst_im_wdata got=%h exp=0000", im_wdata); end
      cmp++; if (ins_index !== 8'h00) begin mism++; $display("FAIL rst_ins_index got=%h exp=00", ins_index); end
      cmp++; if (out_valid !== 1'b0) begin mism++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      cmp++; if (out_data !== 8'h00) begin mism++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
      cmp++; if (out_idx !== 8'h00) begin mism++; $display("FAIL rst_out_idx got=%h exp=00", out_idx); end
      cmp++; if (busy !== 1'b0) begin mism++; $display("FAIL rst_busy got=%b exp=0", busy); end
      cmp++; if (done !== 1'b0) begin mism++; $display("FAIL rst_done got=%b exp=0", done); end
      cmp++; if (err !== 1'b0) begin mism++; $display("FAIL rst_err got=%b exp=0", err); end
      rst_n = 1'b1;
      @(negedge clk);
      cmp++; if (in_ready !== 1'b1) begin mism++; $display("FAIL rst_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      int c0;
      clear_mon();
      prog_w[0] = 16'h1234; prog_w[1] = 16'h5678;
      send_prog(2, 0);
      c0 = last_acc;
      wait_done(100, "basic");
      cmp++; if (we_cyc.size() != 2) begin mism++; $display("FAIL basic_we_count got=%0d exp=2", we_cyc.size()); end
      if (we_cyc.size() == 2) begin
         cmp++; if (we_addr[0] !== 8'd0 || we_data[0] !== 16'h1234) begin
            mism++; $display("FAIL basic_we0 got=%h/%h exp=00/1234", we_addr[0], we_data[0]); end
         cmp++; if (we_addr[1] !== 8'd1 || we_data[1] !== 16'h5678) begin
            mism++; $display("FAIL basic_we1 got=%h/%h exp=01/5678", we_addr[1], we_data[1]); end
`ifdef SCPU_LOADER_CKSUM_EN
         cmp++; if (we_cyc[1] != c0 - 1) begin mism++; $display("FAIL basic_we_cyc got=%0d exp=%0d", we_cyc[1], c0 - 1); end
`else
         cmp++; if (we_cyc[1] != c0) begin mism++; $display("FAIL basic_we_cyc got=%0d exp=%0d", we_cyc[1], c0); end
`endif
      end
      cmp++; if (idx_at[c0] !== 8'd0) begin mism++; $display("FAIL basic_idx_c0 got=%h exp=00", idx_at[c0]); end
      cmp++; if (idx_at[c0+1] !== 8'd1) begin mism++; $display("FAIL basic_idx_c1 got=%h exp=01", idx_at[c0+1]); end
      cmp++; if (rdy_at[c0] !== 1'b0) begin mism++; $display("FAIL basic_run_ready got=%b exp=0", rdy_at[c0]); end
      cmp++; if (ov_cyc.size() != 2) begin mism++; $display("FAIL basic_ov_count got=%0d exp=2", ov_cyc.size()); end
      if (ov_cyc.size() == 2) begin
         cmp++; if (ov_cyc[0] != c0 + PL + 1 || ov_cyc[1] != c0 + PL + 2) begin
            mism++; $display("FAIL basic_ov_cyc got=%0d,%0d exp=%0d,%0d", ov_cyc[0], ov_cyc[1], c0 + 5, c0 + 6); end
         cmp++; if (ov_idx[0] !== 8'd0 || ov_data[0] !== 8'h10) begin
            mism++; $display("FAIL basic_ov0 got=%h/%h exp=00/10", ov_idx[0], ov_data[0]); end
         cmp++; if (ov_idx[1] !== 8'd1 || ov_data[1] !== 8'h11) begin
            mism++; $display("FAIL basic_ov1 got=%h/%h exp=01/11", ov_idx[1], ov_data[1]); end
      end
      cmp++; if (done_cyc.size() != 1) begin mism++; $display("FAIL basic_done_count got=%0d exp=1", done_cyc.size()); end
      if (done_cyc.size() >= 1) begin
         cmp++; if (done_cyc[0] != c0 + 2 + PL + 1) begin
            mism++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc[0], c0 + 7); end
      end
      cmp++; if (in_ready !== 1'b1) begin mism++; $display("FAIL basic_ready_after_done got=%b exp=1", in_ready); end
      cmp++; if (busy !== 1'b0) begin mism++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
      cmp++; if (err !== 1'b0) begin mism++; $display("FAIL basic_err got=%b exp=0", err); end
   endtask

   task automatic test_gaps();
      clear_mon();
      send_byte(8'h00);
      gap(2);
      cmp++; if (busy !== 1'b0) begin mism++; $display("FAIL gaps_zero_hdr_busy got=%b exp=0", busy); end
      cmp++; if (in_ready !== 1'b1) begin mism++; $display("FAIL gaps_zero_hdr_ready got=%b exp=1", in_ready); end
      prog_w[0] = 16'hABCD;
      send_prog(1, 2);
      wait_done(100, "gaps");
      cmp++; if (we_cyc.size() != 1) begin mism++; $display("FAIL gaps_we_count got=%0d exp=1", we_cyc.size()); end
      if (we_cyc.size() == 1) begin
         cmp++; if (we_addr[0] !== 8'd0 || we_data[0] !== 16'hABCD) begin
            mism++; $display("FAIL gaps_we0 got=%h/%h exp=00/abcd", we_addr[0], we_data[0]); end
      end
      cmp++; if (ov_cyc.size() != 1) begin mism++; $display("FAIL gaps_ov_count got=%0d exp=1", ov_cyc.size()); end
      if (ov_cyc.size() == 1) begin
         cmp++; if (ov_idx[0] !== 8'd0 || ov_data[0] !== 8'h10) begin
            mism++; $display("FAIL gaps_ov0 got=%h/%h exp=00/10", ov_idx[0], ov_data[0]); end
      end
      cmp++; if (done_cyc.size() != 1) begin mism++; $display("FAIL gaps_done_count got=%0d exp=1", done_cyc.size()); end
      cmp++; if (err !== 1'b0) begin mism++; $display("FAIL gaps_err got=%b exp=0", err); end
   endtask

`ifdef SCPU_LOADER_CKSUM_EN
   task automatic test_cksum();
      int cf;
      clear_mon();
      prog_w[0] = 16'hF00F;
      send_prog(1, 0);
      wait_done(100, "ck_ok");
      cmp++; if (ov_cyc.size() != 1) begin mism++; $display("FAIL ck_ok_ov_count got=%0d exp=1", ov_cyc.size()); end
      cmp++; if (err !== 1'b0) begin mism++; $display("FAIL ck_ok_err got=%b exp=0", err); end
      clear_mon();
      send_byte(8'h01); send_byte(8'hF0); send_byte(8'h0F); send_byte(8'h00);
      in_valid = 1'b0;
      cf = last_acc;
      wait_done(100, "ck_bad");
      cmp++; if (err !== 1'b1) begin mism++; $display("FAIL ck_bad_err got=%b exp=1", err); end
      cmp++; if (ov_cyc.size() != 0) begin mism++; $display("FAIL ck_bad_ov_count got=%0d exp=0", ov_cyc.size()); end
      cmp++; if (done_cyc.size() != 1) begin mism++; $display("FAIL ck_bad_done_count got=%0d exp=1", done_cyc.size()); end
      if (done_cyc.size() == 1) begin
         cmp++; if (done_cyc[0] != cf) begin mism++; $display("FAIL ck_bad_done_cyc got=%0d exp=%0d", done_cyc[0], cf); end
      end
      repeat (5) @(negedge clk);
      cmp++; if (err !== 1'b1) begin mism++; $display("FAIL ck_err_sticky got=%b exp=1", err); end
   endtask
`else
   task automatic test_cksum();
      clear_mon();
      prog_w[0] = 16'hF00F;
      send_prog(1, 0);
      wait_done(100, "nock");
      cmp++; if (err !== 1'b0) begin mism++; $display("FAIL nock_err got=%b exp=0", err); end
      cmp++; if (ov_cyc.size() != 1) begin mism++; $display("FAIL nock_ov_count got=%0d exp=1", ov_cyc.size()); end
   endtask
`endif

   task automatic test_max();
      int c0, n;
      logic [7:0] e;
      clear_mon();
      for (int i = 0; i < 255; i++) prog_w[i] = {8'(i), 8'(i) ^ 8'hA5};
      send_prog(255, 0);
      c0 = last_acc;
      wait_done(2000, "max");
      cmp++; if (we_cyc.size() != 255) begin mism++; $display("FAIL max_we_count got=%0d exp=255", we_cyc.size()); end
      n = (we_cyc.size() < 255) ? we_cyc.size() : 255;
      for (int i = 0; i < n; i++) begin
         cmp++; if (we_addr[i] !== 8'(i) || we_data[i] !== prog_w[i]) begin
            mism++; $display("FAIL max_we%0d got=%h/%h exp=%h/%h", i, we_addr[i], we_data[i], 8'(i), prog_w[i]); end
      end
      cmp++; if (ov_cyc.size() != 255) begin mism++; $display("FAIL max_ov_count got=%0d exp=255", ov_cyc.size()); end
      n = (ov_cyc.size() < 255) ? ov_cyc.size() : 255;
      for (int i = 0; i < n; i++) begin
         e = 8'(i + 16);
         cmp++; if (ov_idx[i] !== 8'(i) || ov_data[i] !== e) begin
            mism++; $display("FAIL max_ov%0d got=%h/%h exp=%h/%h", i, ov_idx[i], ov_data[i], 8'(i), e); end
      end
      cmp++; if (done_cyc.size() != 1) begin mism++; $display("FAIL max_done_count got=%0d exp=1", done_cyc.size()); end
      if (done_cyc.size() == 1) begin
         cmp++; if (done_cyc[0] != c0 + 255 + PL + 1) begin
            mism++; $display("FAIL max_done_cyc got=%0d exp=%0d", done_cyc[0], c0 + 260); end
      end
   endtask

   task automatic test_reset_mid();
      int t, c0;
      clear_mon();
      for (int i = 0; i < 8; i++) prog_w[i] = 16'h1000 + 16'(i);
      send_prog(8, 0);
      t = 0;
      while (!(busy === 1'b1 && in_ready === 1'b0 && ins_index === 8'd3) && t < 50) begin
         @(negedge clk);
         t++;
      end
      cmp++; if (t >= 50) begin mism++; $display("FAIL rmid_reach_pc3 got=timeout exp=ins_index 3"); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cmp++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
         mism++; $display("FAIL rmid_status got=%b%b%b exp=000", busy, done, in_ready); end
      cmp++; if (ins_index !== 8'd0 || im_we !== 1'b0 || im_addr !== 8'd0 || im_wdata !== 16'd0) begin
         mism++; $display("FAIL rmid_im got=%h/%b/%h/%h exp=00/0/00/0000", ins_index, im_we, im_addr, im_wdata); end
      cmp++; if (out_valid !== 1'b0 || out_data !== 8'd0 || out_idx !== 8'd0 || err !== 1'b0) begin
         mism++; $display("FAIL rmid_out got=%b/%h/%h/%b exp=0/00/00/0", out_valid, out_data, out_idx, err); end
      clear_mon();
      repeat (20) @(negedge clk);
      cmp++; if (ov_cyc.size() != 0) begin mism++; $display("FAIL rmid_no_ov got=%0d exp=0", ov_cyc.size()); end
      cmp++; if (done_cyc.size() != 0) begin mism++; $display("FAIL rmid_no_done got=%0d exp=0", done_cyc.size()); end
      clear_mon();
      send_prog(3, 0);
      c0 = last_acc;
      wait_done(100, "rmid_reload");
      cmp++; if (ov_cyc.size() != 3) begin mism++; $display("FAIL rmid_reload_ov got=%0d exp=3", ov_cyc.size()); end
      if (ov_cyc.size() == 3) begin
         cmp++; if (ov_idx[0] !== 8'd0 || ov_idx[1] !== 8'd1 || ov_idx[2] !== 8'd2 || ov_data[2] !== 8'h12) begin
            mism++; $display("FAIL rmid_reload_idx got=%h,%h,%h/%h exp=00,01,02/12",
                             ov_idx[0], ov_idx[1], ov_idx[2], ov_data[2]); end
      end
      if (done_cyc.size() == 1) begin
         cmp++; if (done_cyc[0] != c0 + 3 + PL + 1) begin
            mism++; $display("FAIL rmid_reload_done got=%0d exp=%0d", done_cyc[0], c0 + 8); end
      end else begin
         cmp++; mism++; $display("FAIL rmid_reload_done_count got=%0d exp=1", done_cyc.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cksum();
      test_gaps();
      test_max();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end

endmodule
